// File: rtl/axi_buf_pkg.sv
// axi_buf_pkg
//   Shared defaults and helpers for the AXI channel buffer.
//   DEF_NUM_CH/DEF_DW/DEF_DEPTH/DEF_AF_MARGIN : default geometry
//   level_width(depth) : bits needed to hold an occupancy of 0..depth
package axi_buf_pkg;

    localparam int DEF_NUM_CH    = 5;   // AW, AR, W, R, B
    localparam int DEF_DW        = 44;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_MARGIN = 1;

    // Occupancy counts 0..depth inclusive, so one more value than a pointer.
    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/axi_sync_chan_fifo.sv
// axi_sync_chan_fifo
//   Single-channel synchronous show-ahead FIFO with a registered ready.
//   clk, rst_n        : clock, asynchronous active-low reset
//   flush             : synchronous discard of all entries
//   s_valid/s_data/s_ready : upstream handshake
//   m_valid/m_data/m_ready : downstream handshake (oldest entry shown)
//   level             : current occupancy 0..DEPTH
//   empty             : high when level is zero
module axi_sync_chan_fifo
    import axi_buf_pkg::*;
#(
    parameter  int DW        = DEF_DW,
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int AF_MARGIN = DEF_AF_MARGIN,
    localparam int LW        = level_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [LW-1:0] level,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    // Ready is withheld once occupancy reaches this mark.
    localparam logic [LW-1:0] HIGH_WATER = LW'(DEPTH - AF_MARGIN);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ready_q;
    logic          push;
    logic          pop;

    // Ready is a flop computed from next-cycle occupancy, so there is no
    // path from m_ready; flush only gates it off while asserted.
    assign s_ready = ready_q & ~flush;
    assign m_valid = (level_q != '0);
    assign m_data  = mem[rd_ptr];
    assign level   = level_q;
    assign empty   = (level_q == '0);

    assign push = s_valid & s_ready;
    assign pop  = m_valid & m_ready & ~flush;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ready_q <= 1'b0;
        end else begin
            level_q <= level_d;
            ready_q <= (level_d < HIGH_WATER);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                // Pointers are exactly log2(DEPTH) bits and wrap naturally.
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; level gates every
    // read, so stale contents are never observed as valid data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: rtl/axi_sync_chan_buffer.sv
// axi_sync_chan_buffer
//   NUM_CH independent AXI handshake channel buffers (AW, AR, W, R, B).
//   Each channel is either a FIFO (axi_sync_chan_fifo) or, when its BYPASS
//   bit is set, a pure wire-through.
//   CLK, RSTN           : clock, asynchronous active-low reset
//   FLUSH               : synchronous discard of all buffered entries
//   S_VALID/S_DATA/S_READY : upstream, channel i payload at [i*DW +: DW]
//   M_VALID/M_DATA/M_READY : downstream, same packing
//   LEVEL               : occupancy per channel, LW bits each
//   EMPTY_FLAG          : per-channel empty indication
module axi_sync_chan_buffer
    import axi_buf_pkg::*;
#(
    parameter  int                NUM_CH    = DEF_NUM_CH,
    parameter  int                DW        = DEF_DW,
    parameter  int                DEPTH     = DEF_DEPTH,
    parameter  int                AF_MARGIN = DEF_AF_MARGIN,
    parameter  logic [NUM_CH-1:0] BYPASS    = '0,
    localparam int                LW        = level_width(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 FLUSH,
    input  logic [NUM_CH-1:0]    S_VALID,
    input  logic [NUM_CH*DW-1:0] S_DATA,
    output logic [NUM_CH-1:0]    S_READY,
    output logic [NUM_CH-1:0]    M_VALID,
    output logic [NUM_CH*DW-1:0] M_DATA,
    input  logic [NUM_CH-1:0]    M_READY,
    output logic [NUM_CH*LW-1:0] LEVEL,
    output logic [NUM_CH-1:0]    EMPTY_FLAG
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        if (BYPASS[i]) begin : g_bypass
            // Wire-through: no storage, flush and reset have no effect.
            assign M_VALID[i]         = S_VALID[i];
            assign M_DATA[i*DW +: DW] = S_DATA[i*DW +: DW];
            assign S_READY[i]         = M_READY[i];
            assign LEVEL[i*LW +: LW]  = '0;
            assign EMPTY_FLAG[i]      = 1'b1;
        end else begin : g_fifo
            axi_sync_chan_fifo #(
                .DW        (DW),
                .DEPTH     (DEPTH),
                .AF_MARGIN (AF_MARGIN)
            ) u_fifo (
                .clk     (CLK),
                .rst_n   (RSTN),
                .flush   (FLUSH),
                .s_valid (S_VALID[i]),
                .s_data  (S_DATA[i*DW +: DW]),
                .s_ready (S_READY[i]),
                .m_valid (M_VALID[i]),
                .m_data  (M_DATA[i*DW +: DW]),
                .m_ready (M_READY[i]),
                .level   (LEVEL[i*LW +: LW]),
                .empty   (EMPTY_FLAG[i])
            );
        end
    end

endmodule
